// File: rtl/trivium_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trivium_ctrl_pkg
// Shared definitions for the Trivium keystream controller: the FSM state
// encoding, the Trivium state size, and the default warm-up and key sizes.
// -----------------------------------------------------------------------------
package trivium_ctrl_pkg;

  // Number of bits in the Trivium internal state (s1..s288).
  localparam int TRIVIUM_STATE_BITS = 288;

  // Trivium discards four full state rotations before producing output.
  localparam int DEFAULT_WARMUP_CYCLES = 4 * TRIVIUM_STATE_BITS;

  // Key and IV are each 80 bits, loaded a byte at a time.
  localparam int DEFAULT_KEY_BYTES = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_WARMUP,
    ST_RUN
  } state_e;

endpackage : trivium_ctrl_pkg

// File: rtl/trivium_ctrl.sv
// -----------------------------------------------------------------------------
// trivium_ctrl
// Sequencing controller that sits beside a Trivium core. It collects the key
// and IV over a byte-wide valid/ready port, pulses the core load, runs the
// warm-up steps with output discarded, then packs core keystream bits into
// bytes on a valid/ready output with backpressure.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_data/valid/ready key then IV bytes, most significant byte first
//   start               one-cycle pulse, starts a session from IDLE
//   ks_data/valid/ready keystream byte output, first-generated bit in bit 7
//   busy                high in every state except IDLE
//   core_key, core_iv   assembled key and IV to the core
//   core_load           one-cycle load strobe to the core
//   core_en             advance the core one step this cycle
//   core_bit            keystream bit of the core's current step
// -----------------------------------------------------------------------------
module trivium_ctrl
  import trivium_ctrl_pkg::*;
#(
  parameter int WARMUP_CYCLES = DEFAULT_WARMUP_CYCLES,
  parameter int KEY_BYTES     = DEFAULT_KEY_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             cfg_data,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   start,
  output logic [7:0]             ks_data,
  output logic                   ks_valid,
  input  logic                   ks_ready,
  output logic                   busy,
  output logic [8*KEY_BYTES-1:0] core_key,
  output logic [8*KEY_BYTES-1:0] core_iv,
  output logic                   core_load,
  output logic                   core_en,
  input  logic                   core_bit
);

  localparam int         KW        = 8 * KEY_BYTES;
  localparam logic [4:0] LAST_BYTE = 5'(2 * KEY_BYTES - 1);
  localparam logic [10:0] LAST_WARM = 11'(WARMUP_CYCLES - 1);

  state_e          state;
  logic [2*KW-1:0] kiv_q;      // key in the upper half, IV in the lower half
  logic [4:0]      byte_cnt;
  logic [10:0]     warm_cnt;
  logic [7:0]      coll_q;     // keystream bits gathered MSB-first
  logic [3:0]      coll_cnt;   // 0..8 bits held in coll_q

  logic coll_full;
  logic slot_free;
  logic run_step;

  // NOTE: every signal written in this always_comb is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    coll_full = (coll_cnt == 4'd8);
    slot_free = !ks_valid || ks_ready;
    // A full collector may only advance if its byte can drain into the slot
    // on this same edge; otherwise the core is frozen so no bit is dropped.
    run_step  = (state == ST_RUN) && (!coll_full || slot_free);
  end

  // core_en depends on this cycle's ks_ready, so it cannot be registered
  // without losing the no-bubble refill.
  assign core_en  = (state == ST_WARMUP) || run_step;
  assign core_key = kiv_q[2*KW-1:KW];
  assign core_iv  = kiv_q[KW-1:0];

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the key/IV shift register is reset too, so key material from
      // an aborted session can never reach the core.
      state     <= ST_IDLE;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      core_load <= 1'b0;
      ks_valid  <= 1'b0;
      ks_data   <= '0;
      kiv_q     <= '0;
      byte_cnt  <= '0;
      warm_cnt  <= '0;
      coll_q    <= '0;
      coll_cnt  <= '0;
    end else begin
      core_load <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOAD;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            byte_cnt  <= '0;
            kiv_q     <= '0;
          end
        end

        ST_LOAD: begin
          // cfg_ready is high for the whole of LOAD, so valid alone means
          // a handshake.
          if (cfg_valid) begin
            kiv_q <= {kiv_q[2*KW-9:0], cfg_data};
            if (byte_cnt == LAST_BYTE) begin
              state     <= ST_INIT;
              cfg_ready <= 1'b0;
              core_load <= 1'b1;
              byte_cnt  <= '0;
            end else begin
              byte_cnt <= byte_cnt + 5'd1;
            end
          end
        end

        ST_INIT: begin
          state    <= ST_WARMUP;
          warm_cnt <= '0;
        end

        ST_WARMUP: begin
          if (warm_cnt == LAST_WARM) begin
            state    <= ST_RUN;
            warm_cnt <= '0;
            coll_q   <= '0;
            coll_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + 11'd1;
          end
        end

        ST_RUN: begin
          if (ks_valid && ks_ready) ks_valid <= 1'b0;
          if (run_step) begin
            if (coll_full) begin
              // Drain and refill on the same edge: the slot takes the byte
              // and the collector restarts with this step's bit.
              ks_data  <= coll_q;
              ks_valid <= 1'b1;
              coll_q   <= {7'd0, core_bit};
              coll_cnt <= 4'd1;
            end else begin
              coll_q   <= {coll_q[6:0], core_bit};
              coll_cnt <= coll_cnt + 4'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : trivium_ctrl

// File: doc/trivium_ctrl.md
TRIVIUM_CTRL -- requirements
Module: trivium_ctrl

Interface
REQ-001 SHALL have parameter WARMUP_CYCLES, default 1152, meaning the number of discarded initialisation steps (4 x 288).
REQ-002 SHALL have parameter KEY_BYTES, default 10, meaning the byte count of the key and of the IV (80 bits each).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_data  input  8  key/IV byte; key bytes first, then IV bytes, each MSB byte first.
REQ-006 cfg_valid  input  1  cfg_data is valid; accepted whenever cfg_ready=1.
REQ-007 cfg_ready  output  1  high only in LOAD.
REQ-008 start  input  1  single-cycle pulse; begins LOAD from IDLE.
REQ-009 ks_data  output  8  keystream byte; first-generated bit in bit 7.
REQ-010 ks_valid  output  1  ks_data holds an unconsumed byte.
REQ-011 ks_ready  input  1  consumer accepts ks_data when ks_valid & ks_ready.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 core_key, core_iv  output  80 each  assembled key/IV to the Trivium core.
REQ-014 core_load  output  1  one-cycle pulse that loads key/IV into the core state.
REQ-015 core_en  output  1  advances the core one step per cycle.
REQ-016 core_bit  input  1  core keystream bit for the current step.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, INIT, WARMUP, RUN.
REQ-018 IDLE -> LOAD on start=1; start in any other state is ignored.
REQ-019 LOAD: each handshake shifts cfg_data into a 160-bit key/IV register; after 2*KEY_BYTES bytes -> INIT.
REQ-020 INIT: core_load=1 for exactly one cycle, then -> WARMUP.
REQ-021 WARMUP: core_en=1 for exactly WARMUP_CYCLES cycles; core_bit is discarded; 11-bit counter; -> RUN after the last step.
REQ-022 RUN: core_en=1 only when the 8-bit collector is not full or the output slot can be written this cycle; core_bit shifts in MSB-first.
REQ-023 When 8 bits are collected and the output slot is empty, or is being consumed in the same cycle, the byte SHALL move to ks_data and ks_valid SHALL be 1 the next cycle.
REQ-024 Simultaneous consume and refill SHALL produce no bubble; sustained ks_ready=1 SHALL yield one byte per 8 cycles.
REQ-025 ks_ready=0 with a full slot and a full collector SHALL hold core_en=0; no bit is lost or duplicated.
REQ-026 ks_data SHALL remain stable while ks_valid=1 and ks_ready=0.
REQ-027 RUN continues until reset; a new start in RUN is ignored.
REQ-028 Byte counter (5 bits) and warm-up counter SHALL never wrap within a state.

Reset
REQ-029 rst_n=0 SHALL force: state IDLE; cfg_ready, ks_valid, busy, core_load, core_en = 0; ks_data, core_key, core_iv, collector, and all counters = 0.
REQ-030 Reset mid-LOAD, WARMUP, or RUN SHALL discard partial key material and partial bytes; the next session requires a fresh start and a full reload.

Structure
REQ-031 The shared package SHALL hold the FSM state enum, TRIVIUM_STATE_BITS=288, and the default WARMUP_CYCLES and KEY_BYTES constants.
REQ-032 The top-level SHALL instantiate trivium_ctrl beside the existing Trivium core, with no other sub-module; the byte packer stays inline.

Verification
REQ-033 Load key=0, IV=0, then stream: bytes SHALL match the Trivium reference-model keystream; first ks_valid SHALL occur 1+1152+8+1 cycles after the last cfg byte.
REQ-034 Count core_en cycles between core_load and RUN entry: SHALL equal exactly 1152, with ks_valid=0 throughout.
REQ-035 Set ks_ready=0 for 40 cycles in RUN: ks_data SHALL stay constant, core_en SHALL be 0 after collector fills, and the resumed byte sequence SHALL equal the model with no gap or repeat.
REQ-036 Set ks_ready=1 continuously: ks_valid handshakes SHALL occur every 8 cycles.
REQ-037 Assert rst_n=0 after 7 of 20 cfg bytes, then reload key=0x80..0 and IV=0: output SHALL match the model for that key, and cfg_ready SHALL be 0 before start.
REQ-038 Hold cfg_valid=0 in LOAD for 10 cycles: no state change, no byte count increment.
